bus_dma_arbiter: RTL and testbench
==================================

Name: bus_dma_arbiter

Overview:
- Memory-mapped DMA engine and bus arbiter for the cpu6502 system bus.
- Sits between the CPU and the shared address/data/WE bus that feeds the ROM, RAM, UART and LED decode.
- The CPU programs source, destination and length through a chip-select window. The block then stalls the CPU via RDY, copies bytes over the shared bus, returns the bus, and optionally raises IRQ.
- Bursts are bounded so the CPU gets periodic bus slots during long transfers.

Parameters:
- BURST, 16: bytes per bus tenure before a forced CPU slot; 0 = no limit.
- GAP, 4: CPU-owned cycles between bursts; must be ≥1.

Ports:
- cclk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cpu_ab  in  16  CPU address bus.
- cpu_do  in  8  CPU write data.
- cpu_we  in  1  CPU write enable, active high.
- cs  in  1  register window select (external decode); register index = cpu_ab[2:0].
- reg_do  out  8  register read data, OR-ed onto the CPU data-in bus.
- bus_di  in  8  shared read data returned by memories/peripherals.
- bus_ab  out  16  arbitrated address to the memories.
- bus_do  out  8  arbitrated write data.
- bus_we  out  1  arbitrated write enable.
- cpu_rdy  out  1  CPU RDY; 1 = CPU runs.
- irq  out  1  interrupt request, active high, level.

Behaviour:
- Registers (index):
  - 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H.
  - 4 LEN: 8-bit; 0 means 256 bytes.
  - 5 CTRL/STAT. Write: bit0 START, bit1 IE, bit2 ACK. Read: bit0 BUSY, bit1 IE, bit7 DONE; other bits 0.
  - 6–7 reserved: read 0, writes ignored.
- Register write occurs on the cclk edge where cs & cpu_we & cpu_rdy.
- Register reads are synchronous: reg_do is valid the cycle after cs & !cpu_we. Otherwise reg_do = 0.
- Reset values: SRC/DST/LEN = 0, IE = 0, DONE = 0, state IDLE, cpu_rdy = 1, irq = 0, bus_we = 0, reg_do = 0.
- Bus mux:
  - In IDLE, GAP and REQ: bus_ab = cpu_ab, bus_do = cpu_do.
  - bus_we = cpu_we in IDLE and GAP only; bus_we = 0 in REQ and REL.
  - In RD, LAT and WR the DMA drives the bus.
- State machine:
  - IDLE: START written (and LEN write in same cycle takes effect first) → REQ next cycle. START clears DONE.
  - REQ: cpu_rdy = 0; dead cycle, no write → RD.
  - RD: bus_ab = SRC, bus_we = 0 → LAT.
  - LAT: capture bus_di into the data latch → WR.
  - WR: bus_ab = DST, bus_do = latch, bus_we = 1. Then SRC += 1, DST += 1 (16-bit wrap FFFF→0000), LEN -= 1 (8-bit), burst counter += 1. Exit conditions:
    - remaining count was 1 → REL with finish flag;
    - BURST≠0 and burst counter reaches BURST → REL;
    - otherwise → RD.
  - REL: cpu_rdy = 0, bus_ab = cpu_ab, so the held CPU address is re-read; data is valid when RDY rises. If finishing → IDLE with DONE = 1; else → GAP.
  - GAP: cpu_rdy = 1 for GAP cycles, burst counter cleared → REQ.
- Cost: 3 cycles per byte, plus 2 cycles per tenure (REQ + REL).
- Final register state after completion: SRC/DST advanced by the byte count; LEN = 0.
- irq = DONE & IE. ACK clears DONE. Writing IE = 0 drops irq without clearing DONE.
- START while BUSY is ignored (reachable only in GAP cycles). LEN = 0 with START copies 256 bytes.
- ACK and START in the same write: DONE cleared, transfer starts.
- Register writes in GAP to SRC/DST/LEN alter the in-flight transfer; this is a defined, unsupported use.
- Reset mid-transfer: immediate return to IDLE, cpu_rdy = 1 on the next cycle, no further bus_we, registers cleared.

Optional Feature:
- DMA_FILL_EN. When defined:
  - CTRL bit3 FILL (read/write).
  - Register 6 = FILL_VAL.
  - With FILL = 1, RD and LAT are skipped: REQ → WR directly, bus_do = FILL_VAL, SRC is not incremented, 1 cycle per byte.
- When undefined: bit3 and register 6 read 0 and ignore writes; copy mode only.

Test Plan:
- Reset → cpu_rdy = 1, irq = 0, bus_we = 0, all registers read 0; assert reset mid-transfer → IDLE next cycle, no further bus_we.
- SRC=FF00, DST=0010, LEN=4, START → RDY low 14 cycles; RAM 0010–0013 = ROM FF00–FF03; SRC reads FF04, DST 0014, LEN 0, DONE = 1.
- BURST=16, GAP=4, LEN=40 → three tenures (16, 16, 8 bytes) separated by exactly 4 cycles with cpu_rdy = 1.
- IE=1, LEN=1 → irq rises after REL; ACK write → irq = 0 next cycle; a second START clears DONE.
- SRC=FFFF, DST=01FF, LEN=2 → reads FFFF then 0000, writes 01FF then 0200 (both wrap/increment); LEN=0 → 256 bytes copied.
- With DMA_FILL_EN: FILL=1, FILL_VAL=A5, DST=0100, LEN=8 → 0100–0107 = A5 at 1 cycle per byte; SRC unchanged.

Source files
------------

// File: rtl/bus_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_dma_arbiter
// Purpose  : Memory-mapped DMA engine and shared-bus arbiter for the cpu6502
//            system bus. The CPU programs SRC/DST/LEN through a register
//            window. The block then holds the CPU with RDY, copies bytes over
//            the shared bus in bounded bursts, returns the bus, and can raise
//            a level IRQ when the transfer is done.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BURST   bytes per bus tenure before a forced CPU slot (0 = unlimited)
//   GAP     CPU-owned cycles between bursts (>= 1)
// Ports
//   cclk      in   system clock
//   reset     in   synchronous, active-high reset
//   cpu_ab    in   CPU address bus (register index = cpu_ab[2:0])
//   cpu_do    in   CPU write data
//   cpu_we    in   CPU write enable
//   cs        in   register window select
//   reg_do    out  registered register read data (0 when not reading)
//   bus_di    in   shared read data from memories/peripherals
//   bus_ab    out  arbitrated address
//   bus_do    out  arbitrated write data
//   bus_we    out  arbitrated write enable
//   cpu_rdy   out  CPU RDY, 1 = CPU runs
//   irq       out  interrupt request (DONE & IE)
// Build option
//   DMA_FILL_EN  adds CTRL bit3 FILL and register 6 FILL_VAL; with FILL set
//                the engine writes FILL_VAL at one cycle per byte.
// ============================================================================
module bus_dma_arbiter #(
  parameter int BURST = 16,
  parameter int GAP   = 4
) (
  input  logic        cclk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  input  logic        cs,
  output logic [7:0]  reg_do,
  input  logic [7:0]  bus_di,
  output logic [15:0] bus_ab,
  output logic [7:0]  bus_do,
  output logic        bus_we,
  output logic        cpu_rdy,
  output logic        irq
);

  localparam int c_BW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam int c_GW = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [c_BW-1:0] c_BURST_MAX = c_BW'(BURST);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(GAP - 1);
  localparam logic            c_BURST_EN  = (BURST != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_LAT  = 3'd3,
    S_WR   = 3'd4,
    S_REL  = 3'd5,
    S_GAP  = 3'd6
  } state_t;

  state_t          r_state, w_state_next;
  logic [15:0]     r_src, r_dst;
  logic [7:0]      r_len, r_latch, r_reg_do;
  logic            r_ie, r_done, r_finish;
  logic [c_BW-1:0] r_burst_cnt;
  logic [c_GW-1:0] r_gap_cnt;

  logic            w_reg_wr, w_ctrl_wr, w_start, w_last, w_burst_full, w_fill;
  logic [2:0]      w_idx;
  logic [c_BW-1:0] w_burst_next;
  logic [7:0]      w_wr_data, w_rd_data;

`ifdef DMA_FILL_EN
  logic       r_fill;
  logic [7:0] r_fill_val;
  assign w_fill    = r_fill;
  assign w_wr_data = r_fill ? r_fill_val : r_latch;
`else
  assign w_fill    = 1'b0;
  assign w_wr_data = r_latch;
`endif

  // Writes only land while the CPU is running (IDLE or GAP).
  assign w_idx        = cpu_ab[2:0];
  assign w_reg_wr     = cs & cpu_we & cpu_rdy;
  assign w_ctrl_wr    = w_reg_wr && (w_idx == 3'd5);
  assign w_start      = w_ctrl_wr && cpu_do[0] && (r_state == S_IDLE);
  assign w_last       = (r_len == 8'd1);
  assign w_burst_next = r_burst_cnt + c_BW'(1);
  assign w_burst_full = c_BURST_EN && (w_burst_next == c_BURST_MAX);

  assign irq    = r_done & r_ie;
  assign reg_do = r_reg_do;

  // Next state and bus mux. The CPU owns the bus by default.
  always_comb begin
    w_state_next = r_state;
    cpu_rdy      = 1'b1;
    bus_ab       = cpu_ab;
    bus_do       = cpu_do;
    bus_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus_we = cpu_we;
        if (w_start) w_state_next = S_REQ;
      end
      S_REQ: begin
        cpu_rdy      = 1'b0;
        w_state_next = w_fill ? S_WR : S_RD;
      end
      S_RD: begin
        cpu_rdy      = 1'b0;
        bus_ab       = r_src;
        bus_do       = r_latch;
        w_state_next = S_LAT;
      end
      S_LAT: begin
        cpu_rdy      = 1'b0;
        bus_ab       = r_src;
        bus_do       = r_latch;
        w_state_next = S_WR;
      end
      S_WR: begin
        cpu_rdy = 1'b0;
        bus_ab  = r_dst;
        bus_do  = w_wr_data;
        bus_we  = 1'b1;
        if (w_last || w_burst_full) w_state_next = S_REL;
        else                        w_state_next = w_fill ? S_WR : S_RD;
      end
      S_REL: begin
        // CPU address is put back so its held read is repeated.
        cpu_rdy      = 1'b0;
        w_state_next = r_finish ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        bus_we = cpu_we;
        if (r_gap_cnt == c_GAP_LAST) w_state_next = S_REQ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Register file, engine datapath and read port.
  always_ff @(posedge cclk) begin
    if (reset) begin
      r_src       <= 16'h0000;
      r_dst       <= 16'h0000;
      r_len       <= 8'h00;
      r_latch     <= 8'h00;
      r_reg_do    <= 8'h00;
      r_ie        <= 1'b0;
      r_done      <= 1'b0;
      r_finish    <= 1'b0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
`ifdef DMA_FILL_EN
      r_fill      <= 1'b0;
      r_fill_val  <= 8'h00;
`endif
    end else begin
      r_reg_do <= (cs && !cpu_we) ? w_rd_data : 8'h00;

      if (w_reg_wr) begin
        case (w_idx)
          3'd0: r_src[7:0]  <= cpu_do;
          3'd1: r_src[15:8] <= cpu_do;
          3'd2: r_dst[7:0]  <= cpu_do;
          3'd3: r_dst[15:8] <= cpu_do;
          3'd4: r_len       <= cpu_do;
          3'd5: begin
            r_ie <= cpu_do[1];
`ifdef DMA_FILL_EN
            r_fill <= cpu_do[3];
`endif
          end
`ifdef DMA_FILL_EN
          3'd6: r_fill_val <= cpu_do;
`endif
          default: ;
        endcase
      end

      // ACK always clears DONE; START only when accepted in IDLE.
      if (w_ctrl_wr && (cpu_do[2] || w_start)) r_done <= 1'b0;
      if (w_start) r_burst_cnt <= '0;

      if (r_state == S_LAT) r_latch <= bus_di;

      if (r_state == S_WR) begin
        if (!w_fill) r_src <= r_src + 16'd1;
        r_dst       <= r_dst + 16'd1;
        r_len       <= r_len - 8'd1;
        r_burst_cnt <= w_burst_next;
        r_finish    <= w_last;
      end

      if (r_state == S_REL) begin
        r_gap_cnt <= '0;
        if (r_finish) r_done <= 1'b1;
      end

      if (r_state == S_GAP) begin
        r_gap_cnt   <= r_gap_cnt + c_GW'(1);
        r_burst_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (w_idx)
      3'd0: w_rd_data = r_src[7:0];
      3'd1: w_rd_data = r_src[15:8];
      3'd2: w_rd_data = r_dst[7:0];
      3'd3: w_rd_data = r_dst[15:8];
      3'd4: w_rd_data = r_len;
      3'd5: w_rd_data = {r_done, 3'b000, w_fill, 1'b0, r_ie, (r_state != S_IDLE)};
`ifdef DMA_FILL_EN
      3'd6: w_rd_data = r_fill_val;
`endif
      default: w_rd_data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_dma_arbiter
// Purpose  : Self-checking bench for bus_dma_arbiter. A synchronous 64 KB
//            memory sits on the shared bus. Each START expands into an
//            expected per-cycle bus trace built from tenure/byte arithmetic,
//            and a reference memory predicts the copied data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_dma_arbiter;

  localparam int BURST = 16;
  localparam int GAP   = 4;
  localparam logic [15:0] c_REG_BASE = 16'hD000;
  localparam logic [15:0] c_IDLE_AB  = 16'h8123;
  localparam logic [7:0]  c_IDLE_DO  = 8'h3C;

  logic        cclk, reset, cpu_we, cs, bus_we, cpu_rdy, irq;
  logic [15:0] cpu_ab, bus_ab;
  logic [7:0]  cpu_do, reg_do, bus_di, bus_do;

  bus_dma_arbiter #(.BURST(BURST), .GAP(GAP)) dut (
    .cclk(cclk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do),
    .cpu_we(cpu_we), .cs(cs), .reg_do(reg_do), .bus_di(bus_di),
    .bus_ab(bus_ab), .bus_do(bus_do), .bus_we(bus_we),
    .cpu_rdy(cpu_rdy), .irq(irq)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  // as: 0 = cpu_ab, 1 = ab, 2 = don't care; ds: 0 = don't care, 1 = cpu_do, 2 = dv
  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [1:0]  as;
    logic [15:0] ab;
    logic [1:0]  ds;
    logic [7:0]  dv;
  } exp_t;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  exp_t        tr[$];
  int          rd_ptr, checks, failures;
  int          lo_q[$], hi_q[$];
  int          run;
  logic        prev_rdy;
  logic [15:0] src_m, dst_m, xfer_d0;
  logic [7:0]  len_m, fill_val_m, rv;
  logic        ie_m, done_m, fill_m;
  int          xfer_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic rdy, input logic we, input logic [1:0] as,
                              input logic [15:0] ab, input logic [1:0] ds, input logic [7:0] dv);
    exp_t e;
    e.rdy = rdy; e.we = we; e.as = as; e.ab = ab; e.ds = ds; e.dv = dv;
    return e;
  endfunction

  task automatic compare();
    exp_t e;
    if (reset) return;
    if (rd_ptr < tr.size()) begin
      e = tr[rd_ptr];
      rd_ptr++;
      chk("trace_rdy", cpu_rdy, e.rdy);
      chk("trace_we", bus_we, e.we);
      if (e.as != 2'd2) chk("trace_ab", bus_ab, (e.as == 2'd0) ? cpu_ab : e.ab);
      if (e.ds != 2'd0) chk("trace_do", bus_do, (e.ds == 2'd1) ? cpu_do : e.dv);
      chk("trace_irq", irq, 0);
    end else begin
      chk("idle_rdy", cpu_rdy, 1);
      chk("idle_we", bus_we, cpu_we);
      chk("idle_ab", bus_ab, cpu_ab);
      chk("idle_do", bus_do, cpu_do);
      chk("idle_irq", irq, done_m & ie_m);
    end
    if (cpu_rdy !== prev_rdy) begin
      if (prev_rdy) hi_q.push_back(run);
      else          lo_q.push_back(run);
      run = 0;
    end
    run++;
    prev_rdy = cpu_rdy;
  endtask

  // One clock: check mid-cycle, then model a synchronous memory.
  task automatic step();
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    @(negedge cclk);
    compare();
    a = bus_ab; w = bus_we & ~cs; d = bus_do;
    @(posedge cclk);
    #1;
    if (w) mem[a] = d;
    bus_di = mem[a];
  endtask

  task automatic push_transfer();
    int          n, i, k;
    logic [15:0] s, d;
    logic [7:0]  dv;
    n = (len_m == 8'd0) ? 256 : int'(len_m);
    s = src_m; d = dst_m; i = 0;
    xfer_d0 = dst_m; xfer_n = n;
    while (i < n) begin
      k = n - i;
      if (BURST != 0 && k > BURST) k = BURST;
      tr.push_back(mk(1'b0, 1'b0, 2'd0, 16'h0, 2'd1, 8'h0));
      for (int j = 0; j < k; j++) begin
        if (fill_m) dv = fill_val_m;
        else begin
          dv = ref_mem[s];
          tr.push_back(mk(1'b0, 1'b0, 2'd1, s, 2'd0, 8'h0));
          tr.push_back(mk(1'b0, 1'b0, 2'd2, 16'h0, 2'd0, 8'h0));
          s = s + 16'd1;
        end
        ref_mem[d] = dv;
        tr.push_back(mk(1'b0, 1'b1, 2'd1, d, 2'd2, dv));
        d = d + 16'd1;
      end
      i += k;
      tr.push_back(mk(1'b0, 1'b0, 2'd0, 16'h0, 2'd0, 8'h0));
      if (i < n) repeat (GAP) tr.push_back(mk(1'b1, 1'b0, 2'd0, 16'h0, 2'd1, 8'h0));
    end
    src_m = s; dst_m = d; len_m = 8'h00;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [7:0] v);
    cs = 1'b1; cpu_we = 1'b1; cpu_ab = c_REG_BASE | {13'h0, idx}; cpu_do = v;
    step();
    cs = 1'b0; cpu_we = 1'b0; cpu_ab = c_IDLE_AB; cpu_do = c_IDLE_DO;
    case (idx)
      3'd0: src_m[7:0]  = v;
      3'd1: src_m[15:8] = v;
      3'd2: dst_m[7:0]  = v;
      3'd3: dst_m[15:8] = v;
      3'd4: len_m       = v;
      3'd5: begin
        ie_m = v[1];
`ifdef DMA_FILL_EN
        fill_m = v[3];
`endif
        if (v[2] || v[0]) done_m = 1'b0;
        if (v[0]) push_transfer();
      end
`ifdef DMA_FILL_EN
      3'd6: fill_val_m = v;
`endif
      default: ;
    endcase
  endtask

  task automatic rd_reg(input logic [2:0] idx, output logic [7:0] v);
    cs = 1'b1; cpu_we = 1'b0; cpu_ab = c_REG_BASE | {13'h0, idx};
    step();
    cs = 1'b0; cpu_ab = c_IDLE_AB;
    v = reg_do;
  endtask

  task automatic check_regs(input string nm);
    logic [7:0] ex [0:7];
    ex[0] = src_m[7:0]; ex[1] = src_m[15:8]; ex[2] = dst_m[7:0]; ex[3] = dst_m[15:8];
    ex[4] = len_m; ex[5] = {done_m, 3'b000, fill_m, 1'b0, ie_m, 1'b0};
    ex[6] = fill_val_m; ex[7] = 8'h00;
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), rv);
      chk($sformatf("%s_reg%0d", nm, r), rv, ex[r]);
    end
  endtask

  task automatic finish_xfer(input string nm);
    int cyc, bad;
    cyc = 0; bad = 0;
    while (rd_ptr < tr.size() && cyc < 4000) begin
      step();
      cyc++;
    end
    chk({nm, "_timeout"}, (rd_ptr < tr.size()), 0);
    rd_ptr = tr.size();
    done_m = 1'b1;
    step();
    for (int k = 0; k < xfer_n; k++)
      if (mem[16'(xfer_d0 + k)] !== ref_mem[16'(xfer_d0 + k)]) bad++;
    chk({nm, "_mem"}, bad, 0);
    check_regs(nm);
  endtask

  task automatic run_xfer(input string nm, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] l, input logic [7:0] ctrl);
    wr_reg(3'd0, s[7:0]); wr_reg(3'd1, s[15:8]);
    wr_reg(3'd2, d[7:0]); wr_reg(3'd3, d[15:8]);
    wr_reg(3'd4, l);
    wr_reg(3'd5, ctrl);
    finish_xfer(nm);
  endtask

  initial begin
    checks = 0; failures = 0; rd_ptr = 0; run = 0; prev_rdy = 1'b1;
    reset = 1'b1; cs = 1'b0; cpu_we = 1'b0; cpu_ab = c_IDLE_AB; cpu_do = c_IDLE_DO;
    bus_di = 8'h00;
    src_m = 16'h0; dst_m = 16'h0; len_m = 8'h0; fill_val_m = 8'h0;
    ie_m = 1'b0; done_m = 1'b0; fill_m = 1'b0; xfer_d0 = 16'h0; xfer_n = 0;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'($urandom);
      ref_mem[a] = mem[a];
    end

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_irq", irq, 0);
    chk("rst_we", bus_we, 0);
    check_regs("rst");

    // Unimplemented bits/registers ignore writes in the copy-only build
    wr_reg(3'd6, 8'h5A);
    wr_reg(3'd7, 8'hC3);
    wr_reg(3'd5, 8'h08);
    check_regs("resv");

    // Directed 4-byte copy
    lo_q.delete(); hi_q.delete();
    run_xfer("copy4", 16'hFF00, 16'h0010, 8'd4, 8'h01);
    chk("copy4_rdy_low", lo_q[lo_q.size()-1], 14);
    rd_reg(3'd0, rv); chk("copy4_srcl", rv, 8'h04);
    rd_reg(3'd1, rv); chk("copy4_srch", rv, 8'hFF);
    rd_reg(3'd2, rv); chk("copy4_dstl", rv, 8'h14);
    rd_reg(3'd5, rv); chk("copy4_ctrl", rv, 8'h80);
    chk("copy4_byte3", mem[16'h0013], mem[16'hFF03]);
    chk("copy4_irq_off", irq, 0);
    wr_reg(3'd5, 8'h04);

    // Burst split 16/16/8 with 4-cycle CPU gaps
    lo_q.delete(); hi_q.delete();
    run_xfer("len40", 16'h3000, 16'h5000, 8'd40, 8'h05);
    chk("len40_tenures", lo_q.size(), 3);
    chk("len40_t0", lo_q[0], 50);
    chk("len40_t1", lo_q[1], 50);
    chk("len40_t2", lo_q[2], 26);
    chk("len40_gap0", hi_q[1], 4);
    chk("len40_gap1", hi_q[2], 4);

    // Interrupt, ACK, IE masking, ACK+START
    run_xfer("irq1", 16'h4000, 16'h6000, 8'd1, 8'h03);
    chk("irq_set", irq, 1);
    wr_reg(3'd5, 8'h06);
    chk("irq_ack", irq, 0);
    run_xfer("irq2", 16'h4100, 16'h6100, 8'd1, 8'h03);
    wr_reg(3'd5, 8'h00);
    chk("irq_masked", irq, 0);
    rd_reg(3'd5, rv); chk("irq_done_kept", rv, 8'h80);
    wr_reg(3'd5, 8'h07);
    rd_reg(3'd5, rv); chk("ackstart_ctrl", rv, 8'h03);
    finish_xfer("ackstart");
    wr_reg(3'd5, 8'h04);

    // Address wrap
    run_xfer("wrap", 16'hFFFF, 16'h01FF, 8'd2, 8'h01);
    rd_reg(3'd0, rv); chk("wrap_srcl", rv, 8'h01);
    rd_reg(3'd1, rv); chk("wrap_srch", rv, 8'h00);
    rd_reg(3'd3, rv); chk("wrap_dsth", rv, 8'h02);

    // LEN = 0 copies 256 bytes in 16 tenures
    lo_q.delete(); hi_q.delete();
    run_xfer("len256", 16'h2000, 16'h7000, 8'd0, 8'h05);
    chk("len256_tenures", lo_q.size(), 16);

`ifdef DMA_FILL_EN
    wr_reg(3'd6, 8'hA5);
    lo_q.delete(); hi_q.delete();
    run_xfer("fill", 16'h1234, 16'h0100, 8'd8, 8'h09);
    chk("fill_rdy_low", lo_q[lo_q.size()-1], 10);
    chk("fill_byte7", mem[16'h0107], 8'hA5);
    rd_reg(3'd1, rv); chk("fill_srch", rv, 8'h12);
    wr_reg(3'd5, 8'h04);
`endif

    // Randomized transfers
    for (int t = 0; t < 6; t++)
      run_xfer($sformatf("rnd%0d", t), 16'($urandom), 16'($urandom),
               8'($urandom_range(1, 40)), {5'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1});

    // Reset in the middle of a transfer
    wr_reg(3'd4, 8'd20);
    wr_reg(3'd5, 8'h03);
    repeat (12) step();
    reset = 1'b1;
    step();
    chk("midrst_rdy", cpu_rdy, 1);
    chk("midrst_we", bus_we, 0);
    reset = 1'b0;
    rd_ptr = tr.size();
    src_m = 16'h0; dst_m = 16'h0; len_m = 8'h0; ie_m = 1'b0; done_m = 1'b0;
    fill_m = 1'b0; fill_val_m = 8'h0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];
    repeat (4) step();
    check_regs("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
